// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: state encoding, watchdog sizing and grant decode shared by the arbiter files.
package wb_arb_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_G0 = 2'd1, ST_G1 = 2'd2} state_e;
    localparam int TO_W = 8;
    localparam logic ERR_TIMEOUT = 1'b1;
    function automatic logic [1:0] gnt_of(state_e s);
        return s == ST_G0 ? 2'b01 : s == ST_G1 ? 2'b10 : 2'b00;
    endfunction
endpackage

// File: rtl/wb_arb_if.sv
// wb_arb_if: both master-side ports plus the intercon-side port of the two-master arbiter.
interface wb_arb_if #(parameter int AW = 32, parameter int DW = 32);
    logic          m0_STB, m0_WE, m0_LOCK, m0_ACK, m0_ERR;
    logic [AW-1:0] m0_ADDR;
    logic [DW-1:0] m0_DAT_I, m0_DAT_O;
    logic          m1_STB, m1_WE, m1_LOCK, m1_ACK, m1_ERR;
    logic [AW-1:0] m1_ADDR;
    logic [DW-1:0] m1_DAT_I, m1_DAT_O;
    logic          s_STB, s_WE, s_ACK;
    logic [AW-1:0] s_ADDR;
    logic [DW-1:0] s_DAT_O, s_DAT_I;
    logic [1:0]    gnt;
    modport slave (
        input  m0_STB, m0_WE, m0_LOCK, m0_ADDR, m0_DAT_I,
        input  m1_STB, m1_WE, m1_LOCK, m1_ADDR, m1_DAT_I,
        input  s_DAT_I, s_ACK,
        output m0_DAT_O, m0_ACK, m0_ERR, m1_DAT_O, m1_ACK, m1_ERR,
        output s_STB, s_WE, s_ADDR, s_DAT_O, gnt
    );
    modport master (
        output m0_STB, m0_WE, m0_LOCK, m0_ADDR, m0_DAT_I,
        output m1_STB, m1_WE, m1_LOCK, m1_ADDR, m1_DAT_I,
        output s_DAT_I, s_ACK,
        input  m0_DAT_O, m0_ACK, m0_ERR, m1_DAT_O, m1_ACK, m1_ERR,
        input  s_STB, s_WE, s_ADDR, s_DAT_O, gnt
    );
endinterface

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: counts stalled granted cycles and flags expiry on the TO_CYCLES-th one.
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TO_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expire_o
);
    logic [TO_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : run ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
    assign expire_o = run && cnt_q == TO_W'(TO_CYCLES - 1);
endmodule

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: round-robin, lockable, watchdog-guarded sharing of one Wishbone port
// between the CPU (m0) and the DMA engine (m1).
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 255
) (
    input logic      clk,
    input logic      rst,
    wb_arb_if.slave  bus
);
    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic          g0, g1, stb, lock, ack, run, expire;
    logic [AW-1:0] addr_fwd;
    logic [DW-1:0] wdat_fwd;
    assign g0       = state_q == ST_G0;
    assign g1       = state_q == ST_G1;
    assign stb      = (g0 & bus.m0_STB) | (g1 & bus.m1_STB);
    assign lock     = g1 ? bus.m1_LOCK : bus.m0_LOCK;
    assign ack      = stb & bus.s_ACK;
    assign run      = stb & ~bus.s_ACK;
    assign addr_fwd = g0 ? bus.m0_ADDR : g1 ? bus.m1_ADDR : '0;
    assign wdat_fwd = g0 ? bus.m0_DAT_I : g1 ? bus.m1_DAT_I : '0;
    wb_arb_watchdog #(.TO_CYCLES(TO_CYCLES)) u_wd (
        .clk(clk), .rst(rst), .clr(~run | expire), .run(run), .expire_o(expire)
    );
    // the expiring cycle withdraws the strobe so the slave never sees a half-terminated access
    assign bus.s_STB    = stb & ~expire;
    assign bus.s_WE     = (g0 & bus.m0_WE) | (g1 & bus.m1_WE);
    assign bus.s_ADDR   = addr_fwd;
    assign bus.s_DAT_O  = wdat_fwd;
    assign bus.m0_DAT_O = g0 ? bus.s_DAT_I : '0;
    assign bus.m1_DAT_O = g1 ? bus.s_DAT_I : '0;
    assign bus.m0_ACK   = g0 & ack;
    assign bus.m1_ACK   = g1 & ack;
    assign bus.m0_ERR   = g0 & expire ? ERR_TIMEOUT : 1'b0;
    assign bus.m1_ERR   = g1 & expire ? ERR_TIMEOUT : 1'b0;
    assign bus.gnt      = gnt_of(state_q);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (state_q == ST_IDLE) begin
            if (bus.m0_STB && (!bus.m1_STB || last_q)) state_d = ST_G0;
            else if (bus.m1_STB) state_d = ST_G1;
        end else if (ack) begin
            last_d  = g1;
            state_d = lock ? state_q : ST_IDLE;
        end else if (expire) begin
            last_d  = g1;
            state_d = ST_IDLE;
        end else if (!stb) begin
            state_d = ST_IDLE;
        end
    end
endmodule
